mem_resp: RTL

Bus-side memory responder for the single-master CPU bus (`data_bus`, `addr_bus`, `wr_en`, `boot`). It is the slave end of the protocol the CPU initiates.
- Holds the word-organised RAM, serves combinational reads, and commits writes on the clock edge.
- During boot it supplies the program image on `data_bus` from a byte-stream loader, buffered in a small word FIFO.
- Sits beside the CPU in the top level and shares its clock and reset.

---
 rtl/mem_resp.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_resp.sv
// mem_resp: word RAM slave on the shared CPU bus, with a byte-stream boot loader feeding a word FIFO.
// Define MEM_RESP_WPROT_EN to block run-mode writes below WP_LIMIT (wp_err pulses on a blocked write).
module mem_resp #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] WP_LIMIT   = 8'h20,
    parameter int         WORD_SIZE  = 16,
    parameter int         ADDR_SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    inout  wire  [WORD_SIZE-1:0] data_bus,
    input  logic [ADDR_SIZE-1:0] addr_bus,
    input  logic                 wr_en,
    input  logic                 boot,
    input  logic [7:0]           ld_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    output logic                 underrun,
    output logic                 boot_done,
    output logic                 wp_err
);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int IDX_W     = ADDR_SIZE - 1;
    localparam int MEM_WORDS = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {LO_WAIT = 1'b0, HI_HELD = 1'b1} asm_state_t;

    logic [WORD_SIZE-1:0] mem_r  [0:MEM_WORDS-1];
    logic [WORD_SIZE-1:0] fifo_r [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    asm_state_t           asm_state_r;
    asm_state_t           asm_next_s;
    logic [7:0]           hi_byte_r;
    logic                 rst_released_r;
    logic                 boot_q_r;
    logic                 underrun_r;
    logic                 boot_done_r;

    logic [IDX_W-1:0]     word_idx_s;
    logic [WORD_SIZE-1:0] head_s;
    logic [WORD_SIZE-1:0] bus_drv_s;
    logic [WORD_SIZE-1:0] wdata_s;
    logic [WORD_SIZE-1:0] asm_word_s;
    logic                 bus_oe_s;
    logic                 fifo_empty_s;
    logic                 accept_s;
    logic                 push_s;
    logic                 hi_load_s;
    logic                 pop_req_s;
    logic                 pop_s;
    logic                 boot_rise_s;
    logic                 boot_fall_s;
    logic                 wr_block_s;
    logic                 mem_we_s;

    // Bit 0 of the byte address is dropped by the shift.
    assign word_idx_s   = IDX_W'(addr_bus >> 1);
    assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
    assign ld_ready     = (count_r != FULL_CNT) & rst_released_r;
    assign accept_s     = ld_valid & ld_ready;
    assign pop_req_s    = boot & wr_en;
    assign pop_s        = pop_req_s & ~fifo_empty_s;
    assign boot_rise_s  = boot & ~boot_q_r;
    assign boot_fall_s  = boot_q_r & ~boot;
    assign head_s       = fifo_empty_s ? {WORD_SIZE{1'b0}} : fifo_r[rd_ptr_r];
    assign asm_word_s   = WORD_SIZE'({hi_byte_r, ld_data});
    assign wdata_s      = boot ? head_s : data_bus;
    assign mem_we_s     = wr_en & ~wr_block_s;
    assign underrun     = underrun_r;
    assign boot_done    = boot_done_r;

`ifdef MEM_RESP_WPROT_EN
    localparam logic [ADDR_SIZE-1:0] WP_LIMIT_A = ADDR_SIZE'(WP_LIMIT);
    logic wp_err_r;

    // Boot writes are trusted; only run-mode writes below the limit are blocked.
    assign wr_block_s = ~boot & (addr_bus < WP_LIMIT_A);

    // Registered pulse in the cycle after a blocked write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_err_r <= 1'b0;
        end else begin
            wp_err_r <= wr_en & wr_block_s;
        end
    end
    assign wp_err = wp_err_r;
`else
    assign wr_block_s = 1'b0;
    assign wp_err     = 1'b0;
`endif

    // Bus driver: FIFO head on boot writes, memory on run reads, otherwise released.
    always_comb begin
        bus_oe_s  = 1'b0;
        bus_drv_s = {WORD_SIZE{1'b0}};
        if (!rst) begin
            bus_oe_s = 1'b0;
        end else if (boot && wr_en) begin
            bus_oe_s  = 1'b1;
            bus_drv_s = head_s;
        end else if (!boot && !wr_en) begin
            bus_oe_s  = 1'b1;
            bus_drv_s = mem_r[word_idx_s];
        end else begin
            bus_oe_s = 1'b0;
        end
    end
    assign data_bus = bus_oe_s ? bus_drv_s : {WORD_SIZE{1'bz}};

    // Word RAM: contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[word_idx_s] <= wdata_s;
        end
    end

    // Byte assembler next state: first byte is the high half, second completes the word.
    always_comb begin
        asm_next_s = asm_state_r;
        push_s     = 1'b0;
        hi_load_s  = 1'b0;
        case (asm_state_r)
            LO_WAIT: begin
                if (accept_s) begin
                    hi_load_s  = 1'b1;
                    asm_next_s = HI_HELD;
                end else begin
                    asm_next_s = LO_WAIT;
                end
            end
            HI_HELD: begin
                if (accept_s) begin
                    push_s     = 1'b1;
                    asm_next_s = LO_WAIT;
                end else begin
                    asm_next_s = HI_HELD;
                end
            end
            default: asm_next_s = LO_WAIT;
        endcase
    end

    // Assembler state and held high byte; end of boot discards a half-built word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_state_r <= LO_WAIT;
            hi_byte_r   <= 8'h00;
        end else if (boot_fall_s) begin
            asm_state_r <= LO_WAIT;
        end else begin
            asm_state_r <= asm_next_s;
            if (hi_load_s) begin
                hi_byte_r <= ld_data;
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_r[wr_ptr_r] <= asm_word_s;
        end
    end

    // FIFO pointers and occupancy; flushed when boot ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (boot_fall_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Boot phase tracking, sticky underrun and end-of-boot pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_released_r <= 1'b0;
            boot_q_r       <= 1'b0;
            underrun_r     <= 1'b0;
            boot_done_r    <= 1'b0;
        end else begin
            rst_released_r <= 1'b1;
            boot_q_r       <= boot;
            boot_done_r    <= boot_fall_s;
            if (pop_req_s && fifo_empty_s) begin
                underrun_r <= 1'b1;
            end else if (boot_rise_s) begin
                underrun_r <= 1'b0;
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end

endmodule
